// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_HOLD = 3'd1,
    NPC_BR   = 3'd2,
    NPC_EXC  = 3'd3,
    NPC_ERET = 3'd4
  } npc_sel_e;

  localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_BASE    = 32'h0000_3000;

endpackage

// File: rtl/pc_if.sv
// Control inputs and fetch-side outputs of the PC generator.
interface pc_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_tgt;
  logic            exc_req;
  logic [XLEN-1:0] exc_pc;
  logic            eret;
  logic            halt_req;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_valid;
  logic            fetch_fault;
  logic [XLEN-1:0] epc;
  logic            halted;

  modport master (
    output stall, redirect, redirect_tgt, exc_req, exc_pc, eret, halt_req,
    input  pc, pc_plus4, fetch_valid, fetch_fault, epc, halted
  );

  modport slave (
    input  stall, redirect, redirect_tgt, exc_req, exc_pc, eret, halt_req,
    output pc, pc_plus4, fetch_valid, fetch_fault, epc, halted
  );
endinterface

// File: rtl/pc_range_chk.sv
// Combinational word-alignment and memory-window check for an address.
module pc_range_chk #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] IM_BASE  = XLEN'(32'h0000_3000),
  parameter int              IM_WORDS = 4096
) (
  input  logic [XLEN-1:0] addr,
  output logic            fault
);

  // One extra bit so base + span cannot wrap past the top of the address space.
  localparam logic [XLEN:0] LO   = {1'b0, IM_BASE};
  localparam logic [XLEN:0] SPAN = (XLEN+1)'(64'(IM_WORDS) * 64'd4);
  localparam logic [XLEN:0] HI   = LO + SPAN - (XLEN+1)'(4);

  logic [XLEN:0] addr_x;
  logic [XLEN:0] lo_diff;
  logic          below;
  logic          above;

  assign addr_x  = {1'b0, addr};
  assign lo_diff = addr_x - LO;
  assign below   = lo_diff[XLEN];
  assign above   = addr_x > HI;
  assign fault   = (addr[1:0] != 2'b00) || below || above;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with BOOT/RUN/HALT control, prioritised next-PC select and EPC.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(DEF_RESET_ADDR),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEF_EXC_VECTOR),
  parameter logic [XLEN-1:0] IM_BASE    = XLEN'(DEF_IM_BASE),
  parameter int              IM_WORDS   = 4096
) (
  input logic clk,
  input logic rst_n,
  pc_if.slave bus
);

  state_e          state_q, state_d;
  npc_sel_e        npc_sel;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] pc_inc;
  logic            fetch_valid;
  logic            range_fault;

  assign pc_inc = pc_q + XLEN'(4);

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    npc_sel = NPC_HOLD;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Halt outranks everything; exception outranks eret, so epc is overwritten.
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (bus.exc_req) begin
          npc_sel = NPC_EXC;
          epc_d   = {bus.exc_pc[XLEN-1:2], 2'b00};
        end else if (bus.eret) begin
          npc_sel = NPC_ERET;
        end else if (bus.redirect) begin
          npc_sel = NPC_BR;
        end else if (bus.stall) begin
          npc_sel = NPC_HOLD;
        end else begin
          npc_sel = NPC_SEQ;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (npc_sel)
      NPC_SEQ:  pc_d = pc_inc;
      NPC_BR:   pc_d = bus.redirect_tgt;
      NPC_EXC:  pc_d = EXC_VECTOR;
      NPC_ERET: pc_d = epc_q;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_ADDR;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  pc_range_chk #(
    .XLEN    (XLEN),
    .IM_BASE (IM_BASE),
    .IM_WORDS(IM_WORDS)
  ) u_range_chk (
    .addr (pc_q),
    .fault(range_fault)
  );

  assign fetch_valid     = (state_q == RUN);
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_inc;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_fault = fetch_valid & range_fault;
  assign bus.epc         = epc_q;
  assign bus.halted      = (state_q == HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit default instance and a 16-bit wrap instance.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pp4;
    logic        fv;
    logic        ff;
    logic [31:0] epc;
    logic        hlt;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        exc;
    logic [31:0] exc_pc;
    logic        eret;
    logic        halt;
    logic [31:0] pc;
    logic        fv;
    logic        ff;
    logic [31:0] epc;
    logic        hlt;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_if #(.XLEN(32)) b32 ();
  pc_if #(.XLEN(16)) b16 ();

  pc_gen u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b32.slave)
  );

  pc_gen #(
    .XLEN      (16),
    .RESET_ADDR(16'hFFF8),
    .EXC_VECTOR(16'h4180),
    .IM_BASE   (16'h0000),
    .IM_WORDS  (16384)
  ) u_dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b16.slave)
  );

  function automatic row_t mk(logic stall, logic redir, logic [31:0] tgt, logic exc,
                              logic [31:0] exc_pc, logic eret, logic halt, logic [31:0] pc,
                              logic fv, logic ff, logic [31:0] epc, logic hlt);
    return '{stall:stall, redir:redir, tgt:tgt, exc:exc, exc_pc:exc_pc, eret:eret, halt:halt,
             pc:pc, fv:fv, ff:ff, epc:epc, hlt:hlt};
  endfunction

  function automatic obs_t obs32();
    return '{pc:b32.pc, pp4:b32.pc_plus4, fv:b32.fetch_valid, ff:b32.fetch_fault,
             epc:b32.epc, hlt:b32.halted};
  endfunction

  function automatic obs_t obs16();
    return '{pc:32'(b16.pc), pp4:32'(b16.pc_plus4), fv:b16.fetch_valid, ff:b16.fetch_fault,
             epc:32'(b16.epc), hlt:b16.halted};
  endfunction

  function automatic obs_t exp_of(row_t r);
    return '{pc:r.pc, pp4:r.pc + 32'd4, fv:r.fv, ff:r.ff, epc:r.epc, hlt:r.hlt};
  endfunction

  task automatic apply(row_t r);
    b32.stall        = r.stall;
    b32.redirect     = r.redir;
    b32.redirect_tgt = r.tgt;
    b32.exc_req      = r.exc;
    b32.exc_pc       = r.exc_pc;
    b32.eret         = r.eret;
    b32.halt_req     = r.halt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t o;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    b16.stall = 0; b16.redirect = 0; b16.redirect_tgt = '0; b16.exc_req = 0;
    b16.exc_pc = '0; b16.eret = 0; b16.halt_req = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('{name:"reset", v:'{pc:32'h3000, pp4:32'h3004, fv:1'b0, ff:1'b0,
                                        epc:32'h0, hlt:1'b0}});
    e = exp_q.pop_front();
    o = obs32();
    n_checks++;
    if (o !== e.v)
      $display("FAIL %s: got pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b, expected pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b",
               e.name, o.pc, o.pp4, o.fv, o.ff, o.epc, o.hlt, e.v.pc, e.v.pp4, e.v.fv, e.v.ff, e.v.epc, e.v.hlt);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    row_t t[$];
    exp_t e;
    obs_t o;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3000, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3008, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h300C, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3010, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back('{name:$sformatf("seq[%0d]", i), v:exp_of(t[i])});
      step();
      e = exp_q.pop_front();
      o = obs32();
      n_checks++;
      if (o !== e.v)
        $display("FAIL %s: got pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b, expected pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b",
                 e.name, o.pc, o.pp4, o.fv, o.ff, o.epc, o.hlt, e.v.pc, e.v.pp4, e.v.fv, e.v.ff, e.v.epc, e.v.hlt);
      else n_pass++;
    end
  endtask

  task automatic test_redirect_stall();
    row_t t[$];
    exp_t e;
    obs_t o;
    t.push_back(mk(1, 1, 32'h3100, 0, 0, 0, 0, 32'h3100, 1, 0, 0, 0));
    t.push_back(mk(0, 1, 32'h3010, 0, 0, 0, 0, 32'h3010, 1, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3010, 1, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h3010, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3014, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3018, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h301C, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3020, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back('{name:$sformatf("redir_stall[%0d]", i), v:exp_of(t[i])});
      step();
      e = exp_q.pop_front();
      o = obs32();
      n_checks++;
      if (o !== e.v)
        $display("FAIL %s: got pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b, expected pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b",
                 e.name, o.pc, o.pp4, o.fv, o.ff, o.epc, o.hlt, e.v.pc, e.v.pp4, e.v.fv, e.v.ff, e.v.epc, e.v.hlt);
      else n_pass++;
    end
  endtask

  task automatic test_exception();
    row_t t[$];
    exp_t e;
    obs_t o;
    t.push_back(mk(0, 0, 0, 1, 32'h301F, 0, 0, 32'h4180, 1, 0, 32'h301C, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h301C, 1, 0, 32'h301C, 0));
    t.push_back(mk(0, 1, 32'h3100, 1, 32'h3044, 1, 0, 32'h4180, 1, 0, 32'h3044, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h3044, 1, 0, 32'h3044, 0));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back('{name:$sformatf("exception[%0d]", i), v:exp_of(t[i])});
      step();
      e = exp_q.pop_front();
      o = obs32();
      n_checks++;
      if (o !== e.v)
        $display("FAIL %s: got pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b, expected pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b",
                 e.name, o.pc, o.pp4, o.fv, o.ff, o.epc, o.hlt, e.v.pc, e.v.pp4, e.v.fv, e.v.ff, e.v.epc, e.v.hlt);
      else n_pass++;
    end
  endtask

  task automatic test_fetch_fault();
    row_t t[$];
    exp_t e;
    obs_t o;
    t.push_back(mk(0, 1, 32'h3002, 0, 0, 0, 0, 32'h3002, 1, 1, 32'h3044, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3006, 1, 1, 32'h3044, 0));
    t.push_back(mk(0, 1, 32'h7000, 0, 0, 0, 0, 32'h7000, 1, 1, 32'h3044, 0));
    t.push_back(mk(0, 1, 32'h2FFC, 0, 0, 0, 0, 32'h2FFC, 1, 1, 32'h3044, 0));
    t.push_back(mk(0, 1, 32'h6FFC, 0, 0, 0, 0, 32'h6FFC, 1, 0, 32'h3044, 0));
    t.push_back(mk(0, 1, 32'h3000, 0, 0, 0, 0, 32'h3000, 1, 0, 32'h3044, 0));
    t.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 32'h3044, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 1, 32'h3044, 0));
    t.push_back(mk(0, 1, 32'h3FFC, 0, 0, 0, 0, 32'h3FFC, 1, 0, 32'h3044, 0));
    t.push_back(mk(0, 1, 32'h3002, 0, 0, 0, 0, 32'h3002, 1, 1, 32'h3044, 0));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back('{name:$sformatf("fetch_fault[%0d]", i), v:exp_of(t[i])});
      step();
      e = exp_q.pop_front();
      o = obs32();
      n_checks++;
      if (o !== e.v)
        $display("FAIL %s: got pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b, expected pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b",
                 e.name, o.pc, o.pp4, o.fv, o.ff, o.epc, o.hlt, e.v.pc, e.v.pp4, e.v.fv, e.v.ff, e.v.epc, e.v.hlt);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    row_t t[$];
    exp_t e;
    obs_t o;
    // pc is misaligned here, so a zero fetch_fault shows the valid mask at work.
    t.push_back(mk(0, 0, 0, 1, 32'h3088, 0, 1, 32'h3002, 0, 0, 32'h3044, 1));
    t.push_back(mk(0, 1, 32'h3100, 1, 32'h3090, 1, 0, 32'h3002, 0, 0, 32'h3044, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3002, 0, 0, 32'h3044, 1));
    foreach (t[i]) begin
      apply(t[i]);
      exp_q.push_back('{name:$sformatf("halt[%0d]", i), v:exp_of(t[i])});
      step();
      e = exp_q.pop_front();
      o = obs32();
      n_checks++;
      if (o !== e.v)
        $display("FAIL %s: got pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b, expected pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b",
                 e.name, o.pc, o.pp4, o.fv, o.ff, o.epc, o.hlt, e.v.pc, e.v.pp4, e.v.fv, e.v.ff, e.v.epc, e.v.hlt);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_halt();
    exp_t e;
    obs_t o;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('{name:"async_reset_32", v:'{pc:32'h3000, pp4:32'h3004, fv:1'b0, ff:1'b0,
                                                 epc:32'h0, hlt:1'b0}});
    exp_q.push_back('{name:"async_reset_16", v:'{pc:32'hFFF8, pp4:32'hFFFC, fv:1'b0, ff:1'b0,
                                                 epc:32'h0, hlt:1'b0}});
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      o = (k == 0) ? obs32() : obs16();
      n_checks++;
      if (o !== e.v)
        $display("FAIL %s: got pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b, expected pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b",
                 e.name, o.pc, o.pp4, o.fv, o.ff, o.epc, o.hlt, e.v.pc, e.v.pp4, e.v.fv, e.v.ff, e.v.epc, e.v.hlt);
      else n_pass++;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap16();
    logic [31:0] pcs[4];
    exp_t e;
    obs_t o;
    pcs[0] = 32'hFFF8;
    pcs[1] = 32'hFFFC;
    pcs[2] = 32'h0000;
    pcs[3] = 32'h0004;
    foreach (pcs[i]) begin
      exp_q.push_back('{name:$sformatf("wrap16[%0d]", i),
                        v:'{pc:pcs[i], pp4:32'((pcs[i] + 32'd4) & 32'hFFFF), fv:1'b1, ff:1'b0,
                            epc:32'h0, hlt:1'b0}});
      step();
      e = exp_q.pop_front();
      o = obs16();
      n_checks++;
      if (o !== e.v)
        $display("FAIL %s: got pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b, expected pc=%h pp4=%h fv=%b ff=%b epc=%h halted=%b",
                 e.name, o.pc, o.pp4, o.fv, o.ff, o.epc, o.hlt, e.v.pc, e.v.pp4, e.v.fv, e.v.ff, e.v.epc, e.v.hlt);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_stall();
    test_exception();
    test_fetch_fault();
    test_halt();
    test_reset_in_halt();
    test_wrap16();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule
